m_program_loader: RTL and testbench
===================================

Name: m_program_loader

Overview:
- Writer-side counterpart to the processor's instruction fetch path: receives a framed byte stream from a host-facing byte source (UART receiver or debug bridge) and writes 32-bit words into the instruction memory write port.
- Holds the core's clock-enable low until a complete frame with a valid checksum has been loaded, then releases it.
- Sits between the byte source and m_proc14 / instruction memory at top level.

Parameters:
- ADDR_W, 12, instruction memory word-address width.
- MAX_WORDS, 4096, largest accepted word count; must be ≤ 2**ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000000, maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- w_clk  in  1  clock.
- w_rst_n  in  1  reset, synchronous, active-low.
- w_in_valid  in  1  byte valid from the source.
- w_in_data  in  8  byte from the source.
- w_in_ready  out  1  loader accepts the byte; a transfer happens when valid && ready on a rising edge.
- w_we  out  1  instruction memory write enable, one-cycle pulse.
- w_addr  out  ADDR_W  instruction memory word address.
- w_wdata  out  32  instruction word.
- w_ce  out  1  processor clock enable.
- w_busy  out  1  a frame is in progress.
- w_err  out  1  sticky error.
- w_nwords  out  ADDR_W+1  number of words written in the last frame.

Behaviour:
- Reset (w_rst_n=0 at a rising edge) applies in any state, including mid-frame:
  - state goes to IDLE.
  - w_we, w_addr, w_wdata, w_ce, w_busy, w_err and w_nwords all go to 0.
  - w_in_ready goes to 1.
- Frame format, in order:
  - SYNC_BYTE.
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - N×4 data bytes, little-endian per word.
  - CSUM: XOR of LEN_LO, LEN_HI and all data bytes.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE: non-sync bytes are accepted and discarded. SYNC_BYTE → LEN0; w_busy=1 and the running XOR clears to 0 on the same edge.
- LEN0: the byte is stored as N[7:0] and XORed into the checksum → LEN1.
- LEN1: the byte is stored as N[15:8] and XORed → DATA, or → CSUM if N==0. If N>MAX_WORDS → ERR instead.
- DATA:
  - A byte counter (0..3) shifts each byte into the word: byte k goes to bits [8k+7:8k].
  - On acceptance of byte 3, the next cycle has w_we=1, w_addr=word index, w_wdata=assembled word. The word index then increments.
  - After word N-1 → CSUM.
  - SYNC_BYTE inside DATA is ordinary data.
- CSUM:
  - Byte == running XOR → DONE; w_nwords=N, w_busy=0, w_ce=1 from the following cycle.
  - Mismatch → ERR.
- DONE: w_ce stays 1. SYNC_BYTE restarts the load (→ LEN0): w_ce=0 and w_busy=1 on the next cycle. Other bytes are discarded.
- ERR: w_err=1, w_ce=0, w_busy=0, w_in_ready=0. The state is left only by reset.
- w_in_ready is 1 in every state except ERR. There is no back-pressure while writing, because each memory write takes one cycle and a single byte beat cannot complete a new word in that cycle.
- Timeout: when TIMEOUT≠0 and the state is LEN0, LEN1, DATA or CSUM, the idle counter counts cycles with no transfer.
  - Counter reaching TIMEOUT → ERR.
  - The counter clears on every accepted byte and on any state change.
- Words already written before an ERR stay in memory. w_ce=0 guarantees that a partially loaded image is never executed.
- Widths: N is held in 16 bits. The word index is ADDR_W+1 bits so that N==MAX_WORDS terminates correctly. w_addr is the low ADDR_W bits of the index.

Decomposition:
- Shared package m_loader_pkg:
  - state encoding constants (IDLE..ERR, 3 bits).
  - SYNC_BYTE default.
  - frame-field byte offsets.
- One sub-module: m_idle_timer.
  - Counter with a clear and an enable input.
  - Output is expired = (count==TIMEOUT), forced to 0 when TIMEOUT==0.

Test Plan:
- Frame A5 01 00 13 00 00 00, CSUM=01^00^13=12 → one pulse of w_we with w_addr=0, w_wdata=32'h00000013; w_ce=1 the cycle after CSUM; w_nwords=1.
- Frame with N=3, including a data byte A5 inside DATA → three writes at addresses 0,1,2 with correct little-endian words; final state DONE.
- Correct frame but CSUM byte flipped → writes occur, then w_err=1, w_ce=0, w_in_ready=0; stays there until w_rst_n=0, after which all outputs are 0.
- LEN=0x1001 (4097 > MAX_WORDS) → ERR immediately after LEN_HI; no w_we pulse. Frame with N=0 and CSUM=00 → DONE, w_nwords=0.
- TIMEOUT=8, stall 8 cycles after the second data byte → ERR; a stall of 7 cycles then continuing → normal completion.
- From DONE, send A5 → w_ce drops the next cycle, and a reload of a 2-word frame overwrites addresses 0–1. Assert w_rst_n=0 mid-DATA → IDLE, w_busy=0, w_ce=0.

Source files
------------

// File: rtl/m_loader_pkg.sv
// m_loader_pkg: shared state encoding and frame constants for the program loader
package m_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_e;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int OFS_SYNC   = 0;
  localparam int OFS_LEN_LO = 1;
  localparam int OFS_LEN_HI = 2;
  localparam int OFS_DATA   = 3;
endpackage

// File: rtl/m_loader_idle_timer.sv
// m_idle_timer: saturating idle-cycle counter, expires at TIMEOUT (never when TIMEOUT==0)
module m_idle_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (!rst_n || clr_i) cnt_q <= '0;
    else if (en_i && cnt_q != LIMIT) cnt_q <= cnt_q + 1'b1;
  assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);
endmodule

// File: rtl/m_program_loader.sv
// m_program_loader: framed byte stream to instruction-memory writes, gates core clock enable
module m_program_loader
  import m_loader_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter int         MAX_WORDS = 4096,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_in_valid,
  input  logic [7:0]        w_in_data,
  output logic              w_in_ready,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_wdata,
  output logic              w_ce,
  output logic              w_busy,
  output logic              w_err,
  output logic [ADDR_W:0]   w_nwords
);
  state_e state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0] csum_q, csum_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] word_q, word_d;
  logic [ADDR_W:0] idx_q, idx_d, nwords_q, nwords_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic xfer, expired;
  assign w_in_ready = state_q != S_ERR;
  assign xfer = w_in_valid && w_in_ready;
  assign w_busy = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  assign w_ce = state_q == S_DONE;
  assign w_err = state_q == S_ERR;
  assign w_we = we_q;
  assign w_addr = addr_q;
  assign w_wdata = wdata_q;
  assign w_nwords = nwords_q;
  m_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(w_clk),
    .rst_n(w_rst_n),
    .clr_i(xfer || state_d != state_q),
    .en_i(w_busy),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    csum_d = csum_q;
    bcnt_d = bcnt_q;
    word_d = word_q;
    idx_d = idx_q;
    nwords_d = nwords_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: if (xfer && w_in_data == SYNC_BYTE) begin
        state_d = S_LEN0;
        csum_d = '0;
        bcnt_d = '0;
        idx_d = '0;
      end
      S_LEN0: if (xfer) begin
        state_d = S_LEN1;
        len_d = {8'h00, w_in_data};
        csum_d = csum_q ^ w_in_data;
      end
      S_LEN1: if (xfer) begin
        len_d = {w_in_data, len_q[7:0]};
        csum_d = csum_q ^ w_in_data;
        state_d = len_d > 16'(MAX_WORDS) ? S_ERR : len_d == 16'd0 ? S_CSUM : S_DATA;
      end
      S_DATA: if (xfer) begin
        csum_d = csum_q ^ w_in_data;
        bcnt_d = bcnt_q + 1'b1;
        word_d = {w_in_data, word_q[23:8]};
        // byte 3 completes the word; the write appears on the following cycle
        if (bcnt_q == 2'd3) begin
          we_d = 1'b1;
          wdata_d = {w_in_data, word_q};
          addr_d = idx_q[ADDR_W-1:0];
          idx_d = idx_q + 1'b1;
          state_d = 16'(idx_d) == len_q ? S_CSUM : S_DATA;
        end
      end
      S_CSUM: if (xfer) begin
        state_d = w_in_data == csum_q ? S_DONE : S_ERR;
        nwords_d = w_in_data == csum_q ? len_q[ADDR_W:0] : nwords_q;
      end
      default: ;
    endcase
    if (expired && w_busy) state_d = S_ERR;
  end
  always_ff @(posedge w_clk)
    if (!w_rst_n) begin
      state_q <= S_IDLE;
      len_q <= '0;
      csum_q <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      idx_q <= '0;
      nwords_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      csum_q <= csum_d;
      bcnt_q <= bcnt_d;
      word_q <= word_d;
      idx_q <= idx_d;
      nwords_q <= nwords_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
endmodule

// File: tb/tb_m_program_loader.sv
// tb_m_program_loader: directed frame vectors plus hand sequences for timeout, reload and reset
module tb_m_program_loader;
  logic w_clk = 1'b0, w_rst_n = 1'b0, w_in_valid = 1'b0;
  logic [7:0] w_in_data = '0;
  logic w_in_ready, w_we, w_ce, w_busy, w_err;
  logic [11:0] w_addr;
  logic [31:0] w_wdata;
  logic [12:0] w_nwords;
  int compared = 0, mismatched = 0;
  logic [11:0] wa[$];
  logic [31:0] wd[$];

  m_program_loader #(.ADDR_W(12), .MAX_WORDS(4096), .SYNC_BYTE(8'hA5), .TIMEOUT(8)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_in_valid(w_in_valid), .w_in_data(w_in_data),
    .w_in_ready(w_in_ready), .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
    .w_ce(w_ce), .w_busy(w_busy), .w_err(w_err), .w_nwords(w_nwords)
  );

  always #5 w_clk = ~w_clk;

  always @(negedge w_clk)
    if (w_rst_n && w_we) begin
      wa.push_back(w_addr);
      wd.push_back(w_wdata);
    end

  typedef struct {
    string name;
    int nb;
    logic [127:0] b;
    logic err, ce, busy;
    int nwr;
    logic [12:0] nw;
    logic [11:0] la;
    logic [31:0] lw;
  } vec_t;
  vec_t v[7];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge w_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    w_in_valid = 1'b1;
    w_in_data = b;
    @(posedge w_clk);
    #1;
    w_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    w_in_valid = 1'b0;
    tick(1);
    w_rst_n = 1'b1;
    wa.delete();
    wd.delete();
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_we"}, 32'(w_we), 0);
    chk({n, "_addr"}, 32'(w_addr), 0);
    chk({n, "_wdata"}, w_wdata, 0);
    chk({n, "_ce"}, 32'(w_ce), 0);
    chk({n, "_busy"}, 32'(w_busy), 0);
    chk({n, "_err"}, 32'(w_err), 0);
    chk({n, "_nwords"}, 32'(w_nwords), 0);
    chk({n, "_ready"}, 32'(w_in_ready), 1);
  endtask

  initial begin
    v[0] = '{"one_word", 8, {64'hA501001300000012, 64'h0}, 0, 1, 0, 1, 1, 0, 32'h00000013};
    v[1] = '{"three_words", 16, 128'hA5030011223344A5667788010203047F, 0, 1, 0, 3, 3, 2, 32'h04030201};
    v[2] = '{"bad_csum", 8, {64'hA5010013000000ED, 64'h0}, 1, 0, 0, 1, 0, 0, 32'h00000013};
    v[3] = '{"len_too_big", 3, {24'hA50110, 104'h0}, 1, 0, 0, 0, 0, 0, 0};
    v[4] = '{"len_zero", 4, {32'hA5000000, 96'h0}, 0, 1, 0, 0, 0, 0, 0};
    v[5] = '{"len_max", 3, {24'hA50010, 104'h0}, 0, 0, 1, 0, 0, 0, 0};
    v[6] = '{"garbage_first", 10, {80'h00FFA501007856341209, 48'h0}, 0, 1, 0, 1, 1, 0, 32'h12345678};

    do_reset();
    chk_zero("reset");

    foreach (v[k]) begin
      do_reset();
      for (int i = 0; i < v[k].nb; i++) send(v[k].b[127-8*i -: 8]);
      tick(2);
      chk({v[k].name, "_err"}, 32'(w_err), 32'(v[k].err));
      chk({v[k].name, "_ready"}, 32'(w_in_ready), 32'(!v[k].err));
      chk({v[k].name, "_ce"}, 32'(w_ce), 32'(v[k].ce));
      chk({v[k].name, "_busy"}, 32'(w_busy), 32'(v[k].busy));
      chk({v[k].name, "_nwr"}, wa.size(), v[k].nwr);
      chk({v[k].name, "_nwords"}, 32'(w_nwords), 32'(v[k].nw));
      if (v[k].nwr > 0 && wa.size() > 0) begin
        chk({v[k].name, "_last_addr"}, 32'(wa[$]), 32'(v[k].la));
        chk({v[k].name, "_last_wdata"}, wd[$], v[k].lw);
      end
    end

    // all three writes of the N=3 frame and the exact w_ce edge
    do_reset();
    for (int i = 0; i < 15; i++) send(v[1].b[127-8*i -: 8]);
    chk("n3_ce_before_csum", 32'(w_ce), 0);
    chk("n3_busy_before_csum", 32'(w_busy), 1);
    send(8'h7F);
    chk("n3_ce_after_csum", 32'(w_ce), 1);
    chk("n3_busy_after_csum", 32'(w_busy), 0);
    chk("n3_writes", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("n3_a0", 32'(wa[0]), 0); chk("n3_d0", wd[0], 32'h44332211);
      chk("n3_a1", 32'(wa[1]), 1); chk("n3_d1", wd[1], 32'h887766A5);
      chk("n3_a2", 32'(wa[2]), 2); chk("n3_d2", wd[2], 32'h04030201);
    end

    // timeout: 8 idle cycles after the second data byte
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h01); send(8'h02);
    tick(8);
    chk("to_not_yet", 32'(w_err), 0);
    tick(1);
    chk("to_err", 32'(w_err), 1);
    chk("to_ready", 32'(w_in_ready), 0);
    send(8'hA5);
    tick(3);
    chk("to_sticky_err", 32'(w_err), 1);
    chk("to_sticky_ce", 32'(w_ce), 0);
    do_reset();
    chk_zero("to_reset");

    // a 7-cycle stall is tolerated
    send(8'hA5); send(8'h02); send(8'h00); send(8'h01); send(8'h02);
    tick(7);
    send(8'h03); send(8'h04); send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    send(8'h0A);
    tick(1);
    chk("stall7_err", 32'(w_err), 0);
    chk("stall7_ce", 32'(w_ce), 1);
    chk("stall7_nwords", 32'(w_nwords), 2);

    // reload from DONE overwrites addresses 0-1
    wa.delete();
    wd.delete();
    send(8'hA5);
    chk("reload_ce_drop", 32'(w_ce), 0);
    chk("reload_busy", 32'(w_busy), 1);
    send(8'h02); send(8'h00);
    send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send(8'h46);
    tick(1);
    chk("reload_ce", 32'(w_ce), 1);
    chk("reload_writes", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("reload_a0", 32'(wa[0]), 0); chk("reload_d0", wd[0], 32'hAABBCCDD);
      chk("reload_a1", 32'(wa[1]), 1); chk("reload_d1", wd[1], 32'h11223344);
    end

    // reset in the middle of DATA
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h01); send(8'h02);
    chk("mid_busy_pre", 32'(w_busy), 1);
    do_reset();
    chk_zero("mid_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
